// File: rtl/kb_div3_pkg.sv
// Shared types and constants for the sequenced divide-by-3 datapath.
package kb_div3_pkg;

  localparam int SIZE_DEF  = 20;
  localparam int CHUNK_DEF = SIZE_DEF / 4;

  // Encodings line up with the sel codes so a step matches when sel == step_ptr.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd2,
    S2   = 3'd3,
    S3   = 3'd4,
    S4   = 3'd5
  } step_t;

  localparam logic [2:0] SEL_LOAD = 3'd1;
  localparam logic [2:0] SEL_LAST = 3'd5;

  function automatic step_t next_step(input step_t s);
    case (s)
      S1:      return S2;
      S2:      return S3;
      S3:      return S4;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/kb_div3_chunk.sv
// Combinational MSB-first mod-3 long-division chain over CHUNK bits.
module kb_div3_chunk #(
  parameter int CHUNK = 5
) (
  input  logic [CHUNK-1:0] bits,
  input  logic [1:0]       rem_in,
  output logic [CHUNK-1:0] qbits,
  output logic [1:0]       rem_out
);

  logic [CHUNK:0][1:0] r;

  assign r[0] = rem_in;

  // Each stage forms t = 2*r + b (max 5), so one conditional subtract keeps r in 0..2.
  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    logic [2:0] t;
    logic       ge3;
    assign t                = {r[i], bits[CHUNK-1-i]};
    assign ge3              = (t >= 3'd3);
    assign qbits[CHUNK-1-i] = ge3;
    assign r[i+1]           = ge3 ? 2'(t - 3'd3) : t[1:0];
  end

  assign rem_out = r[CHUNK];

endmodule

// File: rtl/kb_div3_shift_register.sv
// Divide-by-3 over a shift register, consumed in four strobed chunk steps;
// quotient/remainder are published on the last step only.
module kb_div3_shift_register
  import kb_div3_pkg::*;
#(
  parameter int SIZE = SIZE_DEF
) (
  input  logic            sys_clock,
  input  logic            reset,
  input  logic            shift_en,
  input  logic [2:0]      sel,
  input  logic [SIZE-1:0] divident,
  output logic [SIZE-1:0] quotient,
  output logic [1:0]      reminder
);

  localparam int CHUNK = SIZE / 4;

  step_t            step_ptr;
  logic [SIZE-1:0]  work_sr;
  logic [SIZE-1:0]  q_sr;
  logic [1:0]       rem;

  logic [CHUNK-1:0] qbits;
  logic [1:0]       rem_out;
  logic [SIZE-1:0]  q_next;
  logic             step_hit;

  kb_div3_chunk #(.CHUNK(CHUNK)) u_chunk (
    .bits    (work_sr[SIZE-1 -: CHUNK]),
    .rem_in  (rem),
    .qbits   (qbits),
    .rem_out (rem_out)
  );

  assign q_next   = {q_sr[SIZE-CHUNK-1:0], qbits};
  // IDLE encodes as 0, which no step code uses, so out-of-sequence strobes never hit.
  assign step_hit = (step_ptr != IDLE) && (sel == step_ptr);

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      quotient <= '0;
      reminder <= '0;
      work_sr  <= '0;
      q_sr     <= '0;
      rem      <= '0;
      step_ptr <= IDLE;
    end else if (shift_en) begin
      if (sel == SEL_LOAD) begin
        work_sr  <= divident;
        q_sr     <= '0;
        rem      <= '0;
        step_ptr <= S1;
      end else if (step_hit) begin
        work_sr <= work_sr << CHUNK;
        q_sr    <= q_next;
        rem     <= rem_out;
        if (sel == SEL_LAST) begin
          quotient <= q_next;
          reminder <= rem_out;
          step_ptr <= IDLE;
        end else begin
          step_ptr <= next_step(step_ptr);
        end
      end
    end
  end

endmodule

// File: tb/tb_kb_div3_shift_register.sv
// Self-checking bench: vector table + corner sequences + random dividends, via a scoreboard queue.
module tb_kb_div3_shift_register;

  localparam int SIZE = 20;

  logic            sys_clock = 1'b0;
  logic            reset     = 1'b1;
  logic            shift_en  = 1'b0;
  logic [2:0]      sel       = 3'd0;
  logic [SIZE-1:0] divident  = '0;
  logic [SIZE-1:0] quotient;
  logic [1:0]      reminder;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [SIZE-1:0] d;
    logic [SIZE-1:0] q;
    logic [1:0]      r;
  } vec_t;

  typedef struct {
    logic [SIZE-1:0] q;
    logic [1:0]      r;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[9];

  kb_div3_shift_register #(.SIZE(SIZE)) dut (
    .sys_clock (sys_clock),
    .reset     (reset),
    .shift_en  (shift_en),
    .sel       (sel),
    .divident  (divident),
    .quotient  (quotient),
    .reminder  (reminder)
  );

  always #5 sys_clock = ~sys_clock;

  task automatic drive(input logic en, input logic [2:0] s, input logic [SIZE-1:0] d);
    shift_en = en;
    sel      = s;
    divident = d;
    @(posedge sys_clock);
    #1;
  endtask

  task automatic check(input string name, input logic [SIZE-1:0] q, input logic [1:0] r);
    total++;
    if (quotient !== q || reminder !== r)
      $display("FAIL %s: got quotient=%0d reminder=%0d, expected quotient=%0d reminder=%0d",
               name, quotient, reminder, q, r);
    else
      passed++;
  endtask

  task automatic push_exp(input logic [SIZE-1:0] q, input logic [1:0] r);
    exp_t e;
    e.q = q;
    e.r = r;
    sbq.push_back(e);
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    if (sbq.size() == 0) begin
      total++;
      $display("FAIL %s: scoreboard empty, got quotient=%0d reminder=%0d", name, quotient, reminder);
    end else begin
      e = sbq.pop_front();
      check(name, e.q, e.r);
    end
  endtask

  // Full load + 4 steps; expected result queued when the sequence is launched.
  task automatic run_div(input string name, input logic [SIZE-1:0] d,
                         input logic [SIZE-1:0] q, input logic [1:0] r);
    push_exp(q, r);
    drive(1'b1, 3'd1, d);
    for (int s = 2; s <= 5; s++) drive(1'b1, 3'(s), '0);
    pop_check(name);
  endtask

  initial begin
    logic [SIZE-1:0] d;
    logic [SIZE-1:0] pq;
    logic [1:0]      pr;

    tbl[0] = '{20'd7,       20'd2,      2'd1};
    tbl[1] = '{20'd0,       20'd0,      2'd0};
    tbl[2] = '{20'hFFFFF,   20'd349525, 2'd0};
    tbl[3] = '{20'hFFFFE,   20'd349524, 2'd2};
    tbl[4] = '{20'd9,       20'd3,      2'd0};
    tbl[5] = '{20'd10,      20'd3,      2'd1};
    tbl[6] = '{20'd1,       20'd0,      2'd1};
    tbl[7] = '{20'd2,       20'd0,      2'd2};
    tbl[8] = '{20'd500000,  20'd166666, 2'd2};

    // Reset held for two edges.
    reset = 1'b1;
    drive(1'b0, 3'd0, '0);
    drive(1'b0, 3'd0, '0);
    check("reset", '0, 2'd0);
    reset = 1'b0;

    // Steps without a load must be ignored.
    for (int s = 2; s <= 5; s++) drive(1'b1, 3'(s), 20'd77);
    check("steps_without_load", '0, 2'd0);

    for (int i = 0; i < 9; i++)
      run_div($sformatf("table_%0d", i), tbl[i].d, tbl[i].q, tbl[i].r);

    // shift_en=0: sel toggling through a whole sequence changes nothing.
    drive(1'b0, 3'd1, 20'd7);
    for (int s = 2; s <= 5; s++) drive(1'b0, 3'(s), 20'd7);
    check("hold_shift_en0", 20'd166666, 2'd2);

    // sel=5 held two cycles then shift_en=0: published exactly once.
    push_exp(20'd3, 2'd0);
    drive(1'b1, 3'd1, 20'd9);
    for (int s = 2; s <= 5; s++) drive(1'b1, 3'(s), '0);
    pop_check("sel5_first");
    drive(1'b1, 3'd5, '0);
    check("sel5_held", 20'd3, 2'd0);
    drive(1'b0, 3'd5, '0);
    check("sel5_then_hold", 20'd3, 2'd0);

    // Repeated sel=3 mid-sequence is ignored.
    push_exp(20'd3, 2'd1);
    drive(1'b1, 3'd1, 20'd10);
    drive(1'b1, 3'd2, '0);
    drive(1'b1, 3'd3, '0);
    drive(1'b1, 3'd3, '0);
    drive(1'b1, 3'd4, '0);
    drive(1'b1, 3'd5, '0);
    pop_check("repeat_sel3");

    // Out-of-order step before sel=2 is ignored; load leaves outputs unchanged.
    push_exp(20'd2, 2'd1);
    drive(1'b1, 3'd1, 20'd7);
    check("load_keeps_outputs", 20'd3, 2'd1);
    drive(1'b1, 3'd3, '0);
    for (int s = 2; s <= 5; s++) drive(1'b1, 3'(s), '0);
    pop_check("out_of_order");

    // Restart mid-sequence with a new load.
    push_exp(20'd3, 2'd1);
    drive(1'b1, 3'd1, 20'hFFFFF);
    drive(1'b1, 3'd2, '0);
    drive(1'b1, 3'd3, '0);
    drive(1'b1, 3'd1, 20'd10);
    for (int s = 2; s <= 5; s++) drive(1'b1, 3'(s), '0);
    pop_check("restart");

    // No-op select codes between steps.
    push_exp(20'd11, 2'd2);
    drive(1'b1, 3'd1, 20'd35);
    drive(1'b1, 3'd2, '0);
    drive(1'b1, 3'd0, '0);
    drive(1'b1, 3'd6, '0);
    drive(1'b1, 3'd3, '0);
    drive(1'b1, 3'd7, '0);
    drive(1'b1, 3'd4, '0);
    drive(1'b1, 3'd5, '0);
    pop_check("noop_codes");

    // Reset asserted at sel=4 aborts; a following sel=5 finds step_ptr IDLE.
    drive(1'b1, 3'd1, 20'd100);
    drive(1'b1, 3'd2, '0);
    drive(1'b1, 3'd3, '0);
    reset = 1'b1;
    drive(1'b1, 3'd4, '0);
    reset = 1'b0;
    check("reset_mid_seq", '0, 2'd0);
    drive(1'b1, 3'd5, '0);
    check("sel5_after_reset", '0, 2'd0);

    // Random dividends, sequence 1,2,3,4,5,5,0.
    pq = '0;
    pr = '0;
    for (int i = 0; i < 64; i++) begin
      d = SIZE'($urandom_range(0, 32'hFFFFF));
      push_exp(d / 20'd3, 2'(d % 20'd3));
      drive(1'b1, 3'd1, d);
      drive(1'b1, 3'd2, '0);
      drive(1'b1, 3'd3, '0);
      drive(1'b1, 3'd4, '0);
      if (i % 8 == 0) check($sformatf("rand_pre_%0d", i), pq, pr);
      drive(1'b1, 3'd5, '0);
      drive(1'b1, 3'd5, '0);
      drive(1'b1, 3'd0, '0);
      pq = d / 20'd3;
      pr = 2'(d % 20'd3);
      pop_check($sformatf("rand_%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
